seq_fixed_divider: RTL and testbench
====================================

// Module: seq_fixed_divider
// PURPOSE
// - Sequential radix-2 restoring fixed-point divider, the inverse of the constant multiplier path.
// - Computes quotient = (dividend << FRAC) / divisor, one quotient bit per cycle.
// - Used for dequantisation / reciprocal scaling in the image decompression path.
// - valid/ready on both sides; one division in flight.
// PARAMETERS
// - IN_W     32  dividend/quotient width; signed two's complement
// - DIV_W    16  divisor width; unsigned, Q(DIV_W-FRAC).FRAC
// - FRAC     15  fractional bits of divisor; requires FRAC < DIV_W
// PORTS
// - clk         in   1      clock; all state updates on rising edge
// - rst         in   1      synchronous, active-high reset
// - in_valid    in   1      dividend/divisor valid
// - in_ready    out  1      divider can accept; high only in IDLE
// - dividend    in   IN_W   signed numerator, same Q format as quotient
// - divisor     in   DIV_W  unsigned denominator
// - out_valid   out  1      quotient/flags valid; high only in DONE
// - out_ready   in   1      consumer accepts result
// - quotient    out  IN_W   signed result; truncated toward zero, saturated
// - div_by_zero out  1      divisor was 0; valid with out_valid
// - overflow    out  1      result saturated (includes div_by_zero); valid with out_valid
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0, overflow=0.
//   Reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
// - FSM states:
//   - IDLE: in_valid&in_ready captures operands. divisor==0 -> DONE, else -> CALC.
//   - CALC: one iteration per cycle, counter N-1..0. Exit to DONE when count==0.
//   - DONE: hold outputs stable. out_valid&out_ready -> IDLE.
// - Iteration count: N = IN_W+FRAC (47 at defaults).
// - Latency:
//   - out_valid rises N+1 cycles after the accepting edge.
//   - divisor==0: out_valid rises 1 cycle after the accepting edge.
// - Throughput: in_ready=0 outside IDLE. Next accept is no earlier than the cycle after the output handshake.
// - Arithmetic:
//   - mag = |dividend| in IN_W unsigned bits; |-2^(IN_W-1)| = 2^(IN_W-1) is exact.
//   - Numerator = mag<<FRAC (IN_W+FRAC bits); remainder register DIV_W+1 bits.
//   - Quotient magnitude is IN_W+FRAC bits; sign = dividend sign.
// - Saturation (overflow=1):
//   - positive result with magnitude > 2^(IN_W-1)-1 -> 2^(IN_W-1)-1
//   - negative result with magnitude > 2^(IN_W-1) -> -2^(IN_W-1)
// - Divide by zero: quotient=0x7FFF_FFFF if dividend>=0, else 0x8000_0000; div_by_zero=1, overflow=1.
// - Zero result: a negative dividend whose magnitude result is 0 gives quotient=0, never -0.
// - Handshake: in_valid may drop without effect while in_ready=0. Operands are sampled only on the accept edge.
// CONFIGURATION
// - DIVIDER_ROUND_EN defined:
//   - N = IN_W+FRAC+1; the extra iteration yields a half-LSB bit.
//   - Magnitude is incremented when that bit is 1 (round half away from zero), before saturation.
//   - Latency becomes N+1 with the new N.
// - DIVIDER_ROUND_EN undefined: truncation toward zero, N = IN_W+FRAC.
// - div_by_zero behaviour is identical in both builds.
// TESTING (defaults IN_W=32, DIV_W=16, FRAC=15)
// - dividend=0x0000_8000, divisor=0x4000 -> quotient=0x0001_0000, flags 0, out_valid at cycle 48 after accept.
// - dividend=0xFFFF_8000, divisor=0x8000 -> quotient=0xFFFF_8000, flags 0.
// - dividend=1, divisor=3:
//   - default build -> 0x0000_2AAA
//   - DIVIDER_ROUND_EN -> 0x0000_2AAB, latency 49
// - dividend=0x7FFF_FFFF, divisor=1 -> quotient=0x7FFF_FFFF, overflow=1.
// - dividend=0x8000_0000, divisor=0 -> quotient=0x8000_0000, div_by_zero=1, overflow=1, out_valid 1 cycle after accept.
// - out_ready held 0 for 10 cycles in DONE -> quotient/flags stable, in_ready=0, then IDLE after handshake.
// - rst pulsed at CALC iteration 10 -> next cycle out_valid=0, in_ready=1; no spurious result afterwards.

Source files
------------

// File: rtl/seq_fixed_divider.sv
// seq_fixed_divider: radix-2 restoring fixed-point divider.
// quotient = (dividend << FRAC) / divisor, one quotient bit per cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake (ready only in IDLE)
//   dividend [IN_W]           signed numerator
//   divisor  [DIV_W]          unsigned Q(DIV_W-FRAC).FRAC denominator
//   out_valid/out_ready       result handshake (valid only in DONE)
//   quotient [IN_W]           signed result, truncated toward zero, saturated
//   div_by_zero, overflow     result flags, valid with out_valid
//
// Optional build macro: DIVIDER_ROUND_EN
//   adds a half-LSB iteration and rounds half away from zero.
module seq_fixed_divider #(
  parameter int IN_W  = 32,
  parameter int DIV_W = 16,
  parameter int FRAC  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IN_W-1:0]  quotient,
  output logic             div_by_zero,
  output logic             overflow
);

`ifdef DIVIDER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  // Numerator / quotient share one shift register of NUM_W bits.
  localparam int NUM_W = IN_W + FRAC + RND;
  // One spare bit so the rounding increment cannot wrap.
  localparam int MAG_W = IN_W + FRAC + 1;
  localparam int CNT_W = $clog2(NUM_W);

  localparam logic [IN_W-1:0] Q_MAX =
    {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] Q_MIN =
    {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] POS_LIM =
    {{(MAG_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] NEG_LIM =
    {{(MAG_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [NUM_W-1:0] r_acc;
  logic [DIV_W:0]   r_rem;
  logic [DIV_W-1:0] r_div;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [IN_W-1:0]  r_quot;
  logic             r_dbz;
  logic             r_ovf;

  logic [IN_W-1:0]  w_mag;
  logic             w_div_zero;
  logic [DIV_W:0]   w_rem_sh;
  logic             w_ge;
  logic [DIV_W:0]   w_rem_nx;
  logic [NUM_W-1:0] w_acc_nx;
  logic [MAG_W-1:0] w_mag_q;
  logic [IN_W-1:0]  w_fin_q;
  logic             w_fin_ovf;

  // |dividend| as unsigned; -2^(IN_W-1) maps to 2^(IN_W-1) exactly.
  assign w_mag = dividend[IN_W-1]
               ? IN_W'(0) - dividend
               : dividend;
  assign w_div_zero = (divisor == '0);

  // The remainder stays below the divisor, so the shifted
  // value always fits DIV_W+1 bits; the top bit drops out.
  assign w_rem_sh = (DIV_W+1)'({r_rem, r_acc[NUM_W-1]});
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge
                  ? w_rem_sh - {1'b0, r_div}
                  : w_rem_sh;
  assign w_acc_nx = {r_acc[NUM_W-2:0], w_ge};

  always_comb begin
`ifdef DIVIDER_ROUND_EN
    w_mag_q = MAG_W'(w_acc_nx[NUM_W-1:1])
            + MAG_W'(w_acc_nx[0]);
`else
    w_mag_q = MAG_W'(w_acc_nx);
`endif
  end

  always_comb begin
    w_fin_q   = '0;
    w_fin_ovf = 1'b0;
    if (!r_neg) begin
      if (w_mag_q > POS_LIM) begin
        w_fin_q   = Q_MAX;
        w_fin_ovf = 1'b1;
      end else begin
        w_fin_q = w_mag_q[IN_W-1:0];
      end
    end else begin
      if (w_mag_q > NEG_LIM) begin
        w_fin_q   = Q_MIN;
        w_fin_ovf = 1'b1;
      end else begin
        // A zero magnitude negates to 0, never -0.
        w_fin_q = IN_W'(0) - w_mag_q[IN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid)
          w_state_nx = w_div_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == '0) w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_neg <= dividend[IN_W-1];
            r_div <= divisor;
            r_rem <= '0;
            r_acc <= {w_mag, {(FRAC+RND){1'b0}}};
            r_cnt <= CNT_W'(NUM_W-1);
            if (w_div_zero) begin
              r_quot <= dividend[IN_W-1] ? Q_MIN : Q_MAX;
              r_dbz  <= 1'b1;
              r_ovf  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_quot <= w_fin_q;
            r_dbz  <= 1'b0;
            r_ovf  <= w_fin_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_fixed_divider.sv
// tb_seq_fixed_divider: directed vector bench for seq_fixed_divider.
// Table of hand-computed results plus stall and reset sequences.
module tb_seq_fixed_divider;

`ifdef DIVIDER_ROUND_EN
  localparam int N = 48;
`else
  localparam int N = 47;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        overflow;

  always #5 clk = ~clk;

  seq_fixed_divider dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [31:0] q;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [15:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  vec_t tv[15];
  int   lat;
  int   seen;

  initial begin
    tv[0]  = '{32'h0000_8000, 16'h4000, 32'h0001_0000,
               1'b0, 1'b0, N+1};
    tv[1]  = '{32'hFFFF_8000, 16'h8000, 32'hFFFF_8000,
               1'b0, 1'b0, N+1};
`ifdef DIVIDER_ROUND_EN
    tv[2]  = '{32'h0000_0001, 16'h0003, 32'h0000_2AAB,
               1'b0, 1'b0, N+1};
    tv[7]  = '{32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF,
               1'b0, 1'b0, N+1};
    tv[11] = '{32'hFFFF_FFFF, 16'h0003, 32'hFFFF_D555,
               1'b0, 1'b0, N+1};
`else
    tv[2]  = '{32'h0000_0001, 16'h0003, 32'h0000_2AAA,
               1'b0, 1'b0, N+1};
    tv[7]  = '{32'hFFFF_FFFF, 16'hFFFF, 32'h0000_0000,
               1'b0, 1'b0, N+1};
    tv[11] = '{32'hFFFF_FFFF, 16'h0003, 32'hFFFF_D556,
               1'b0, 1'b0, N+1};
`endif
    tv[3]  = '{32'h7FFF_FFFF, 16'h0001, 32'h7FFF_FFFF,
               1'b0, 1'b1, N+1};
    tv[4]  = '{32'h8000_0000, 16'h0000, 32'h8000_0000,
               1'b1, 1'b1, 1};
    tv[5]  = '{32'h0000_0005, 16'h0000, 32'h7FFF_FFFF,
               1'b1, 1'b1, 1};
    tv[6]  = '{32'h0000_0000, 16'h0000, 32'h7FFF_FFFF,
               1'b1, 1'b1, 1};
    tv[8]  = '{32'h8000_0000, 16'h8000, 32'h8000_0000,
               1'b0, 1'b0, N+1};
    tv[9]  = '{32'h4000_0000, 16'h4000, 32'h7FFF_FFFF,
               1'b0, 1'b1, N+1};
    tv[10] = '{32'hC000_0000, 16'h2000, 32'h8000_0000,
               1'b0, 1'b1, N+1};
    tv[12] = '{32'h0000_0000, 16'h1234, 32'h0000_0000,
               1'b0, 1'b0, N+1};
    tv[13] = '{32'h0000_0064, 16'h8000, 32'h0000_0064,
               1'b0, 1'b0, N+1};
    tv[14] = '{32'h0003_0000, 16'h6000, 32'h0004_0000,
               1'b0, 1'b0, N+1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 15; i++) begin
      start(tv[i].dvd, tv[i].dvs);
      wait_done(lat);
      chk($sformatf("v%0d_q", i), quotient, tv[i].q);
      chk($sformatf("v%0d_dbz", i),
          32'(div_by_zero), 32'(tv[i].dz));
      chk($sformatf("v%0d_ovf", i),
          32'(overflow), 32'(tv[i].ov));
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_busy", i),
          32'(in_ready), 32'd0);
      handshake();
    end

    // Stall in DONE while in_valid chatters.
    start(32'h0000_8000, 16'h4000);
    wait_done(lat);
    chk("stall_lat", lat, N+1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'h1234_5678;
      divisor  = 16'h0000;
      @(posedge clk);
      #1;
      chk("stall_q", quotient, 32'h0001_0000);
      chk("stall_flags",
          {30'd0, div_by_zero, overflow}, 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    start(32'h0000_0064, 16'h8000);
    wait_done(lat);
    chk("post_stall_q", quotient, 32'h0000_0064);
    chk("post_stall_dbz", 32'(div_by_zero), 32'd0);
    handshake();

    // Reset during CALC aborts the division.
    start(32'h0000_0001, 16'h0003);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", quotient, 32'd0);
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_spurious", seen, 0);

    start(32'hFFFF_8000, 16'h8000);
    wait_done(lat);
    chk("post_abort_q", quotient, 32'hFFFF_8000);
    chk("post_abort_lat", lat, N+1);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
